// File: rtl/issue_queue_pkg.sv
// issue_queue_pkg: shared sizing, entry layout and wakeup tag match for the issue queue
package issue_queue_pkg;
  localparam int DISPATCH_WIDTH = 2;
  localparam int PHYS_REGS_ADDR_WIDTH = 6;
  localparam int IQ_DEPTH = 8;
  localparam int WAKEUP_WIDTH = 2;
  localparam int CTRL_WIDTH = 8;
  localparam int IDX_W = $clog2(IQ_DEPTH);
  typedef struct packed {
    logic busy;
    logic [31:0] op1;
    logic op1_valid;
    logic [31:0] op2;
    logic op2_valid;
    logic [PHYS_REGS_ADDR_WIDTH-1:0] rd;
    logic [CTRL_WIDTH-1:0] ctrl;
  } iq_entry_t;
  function automatic logic tag_hit(
    input logic [WAKEUP_WIDTH-1:0] v,
    input logic [WAKEUP_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] tags,
    input logic [PHYS_REGS_ADDR_WIDTH-1:0] t
  );
    tag_hit = 1'b0;
    for (int k = 0; k < WAKEUP_WIDTH; k++) tag_hit = tag_hit | (v[k] && tags[k] == t);
  endfunction
endpackage

// File: rtl/issue_queue_select.sv
// iq_select: lowest-index set-bit priority encoder with a found flag
module iq_select
  import issue_queue_pkg::*;
#(
  parameter int N = IQ_DEPTH
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);
  localparam int W = $clog2(N);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = W'(i);
  end
  assign found = |req;
endmodule

// File: rtl/issue_queue.sv
// issue_queue: unified OoO issue queue with dispatch-cycle wakeup and lowest-index select
module issue_queue
  import issue_queue_pkg::*;
(
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 flush,
  input  logic [DISPATCH_WIDTH-1:0]                            dispatch_valid,
  output logic                                                 dispatch_ready,
  input  logic [DISPATCH_WIDTH-1:0][31:0]                      op1,
  input  logic [DISPATCH_WIDTH-1:0][31:0]                      op2,
  input  logic [DISPATCH_WIDTH-1:0]                            op1_valid,
  input  logic [DISPATCH_WIDTH-1:0]                            op2_valid,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]  rd,
  input  logic [DISPATCH_WIDTH-1:0][CTRL_WIDTH-1:0]            ctrl,
  input  logic [WAKEUP_WIDTH-1:0]                              wakeup_valid,
  input  logic [WAKEUP_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]    wakeup_tag,
  output logic                                                 issue_valid,
  input  logic                                                 issue_ready,
  output logic [31:0]                                          issue_op1,
  output logic [31:0]                                          issue_op2,
  output logic [PHYS_REGS_ADDR_WIDTH-1:0]                      issue_rd,
  output logic [CTRL_WIDTH-1:0]                                issue_ctrl
);
  localparam int FW = $clog2(IQ_DEPTH + 1);
  localparam int LW = $clog2(DISPATCH_WIDTH + 1);
  iq_entry_t q [IQ_DEPTH];
  iq_entry_t q_n [IQ_DEPTH];
  logic [IQ_DEPTH-1:0] busy, rdy;
  logic [FW-1:0] n_free;
  logic [IDX_W-1:0] sel, tgt;
  logic [DISPATCH_WIDTH-1:0][IDX_W-1:0] slot;
  logic [LW-1:0] n;
  always_comb begin
    n_free = '0;
    for (int e = 0; e < IQ_DEPTH; e++) begin
      busy[e] = q[e].busy;
      rdy[e] = q[e].busy && q[e].op1_valid && q[e].op2_valid;
      n_free = n_free + FW'(!q[e].busy);
    end
  end
  assign dispatch_ready = n_free >= FW'(DISPATCH_WIDTH);
  iq_select #(.N(IQ_DEPTH)) u_issue_sel (.req(rdy), .idx(sel), .found(issue_valid));
  assign issue_op1 = q[sel].op1;
  assign issue_op2 = q[sel].op2;
  assign issue_rd = q[sel].rd;
  assign issue_ctrl = q[sel].ctrl;
  // Each stage claims the lowest remaining free slot and masks it for the next lane.
  for (genvar i = 0; i < DISPATCH_WIDTH; i++) begin : g_free
    logic [IQ_DEPTH-1:0] m, hit;
    logic ok;
    if (i == 0) begin : g_first
      assign m = ~busy;
    end else begin : g_next
      assign m = g_free[i-1].m & ~g_free[i-1].hit;
    end
    iq_select #(.N(IQ_DEPTH)) u_free_sel (.req(m), .idx(slot[i]), .found(ok));
    assign hit = {IQ_DEPTH{ok}} & (IQ_DEPTH'(1) << slot[i]);
  end
  always_comb begin
    q_n = q;
    n = '0;
    tgt = '0;
    for (int e = 0; e < IQ_DEPTH; e++) begin
      if (q[e].busy && !q[e].op1_valid && tag_hit(wakeup_valid, wakeup_tag, q[e].op1[PHYS_REGS_ADDR_WIDTH-1:0]))
        q_n[e].op1_valid = 1'b1;
      if (q[e].busy && !q[e].op2_valid && tag_hit(wakeup_valid, wakeup_tag, q[e].op2[PHYS_REGS_ADDR_WIDTH-1:0]))
        q_n[e].op2_valid = 1'b1;
    end
    if (issue_valid && issue_ready) q_n[sel].busy = 1'b0;
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      if (dispatch_ready && dispatch_valid[l]) begin
        for (int j = 0; j < DISPATCH_WIDTH; j++) if (n == LW'(j)) tgt = slot[j];
        q_n[tgt] = '{
          busy: 1'b1,
          op1: op1[l],
          op1_valid: op1_valid[l] || tag_hit(wakeup_valid, wakeup_tag, op1[l][PHYS_REGS_ADDR_WIDTH-1:0]),
          op2: op2[l],
          op2_valid: op2_valid[l] || tag_hit(wakeup_valid, wakeup_tag, op2[l][PHYS_REGS_ADDR_WIDTH-1:0]),
          rd: rd[l],
          ctrl: ctrl[l]
        };
        n = n + LW'(1);
      end
    end
    if (flush) for (int e = 0; e < IQ_DEPTH; e++) q_n[e].busy = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) for (int e = 0; e < IQ_DEPTH; e++) q[e].busy <= 1'b0;
    else q <= q_n;
  end
endmodule

// File: doc/issue_queue.md
# issue_queue

Unified out-of-order issue queue between the dispatch stage and the execute pipelines. Each cycle it accepts up to DISPATCH_WIDTH renamed instructions with resolved operands and operand-valid flags. It snoops result-tag broadcasts to wake pending operands, and issues one fully-ready instruction per cycle under a valid/ready handshake.

## Interface
- DISPATCH_WIDTH, from parameters.sv: dispatch lanes.
- PHYS_REGS_ADDR_WIDTH, from parameters.sv: physical register tag width.
- IQ_DEPTH, 8: number of entries; power of two, ≥ DISPATCH_WIDTH.
- WAKEUP_WIDTH, 2: number of tag broadcast ports.
- CTRL_WIDTH, 8: width of the opaque execute-control payload.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  pipeline flush; discard all entries.
- dispatch_valid  in  1 ×DISPATCH_WIDTH  lane carries an instruction.
- dispatch_ready  out  1  queue can accept a full dispatch group this cycle.
- op1, op2  in  32 ×DISPATCH_WIDTH  operand: immediate, or a physical tag in the low PHYS_REGS_ADDR_WIDTH bits.
- op1_valid, op2_valid  in  1 ×DISPATCH_WIDTH  operand holds a value (1) or a pending tag (0).
- rd  in  PHYS_REGS_ADDR_WIDTH ×DISPATCH_WIDTH  destination tag.
- ctrl  in  CTRL_WIDTH ×DISPATCH_WIDTH  execute control.
- wakeup_valid  in  1 ×WAKEUP_WIDTH  broadcast valid.
- wakeup_tag  in  PHYS_REGS_ADDR_WIDTH ×WAKEUP_WIDTH  produced tag.
- issue_valid  out  1  an entry is being presented.
- issue_ready  in  1  execute accepts.
- issue_op1, issue_op2  out  32  operands of the issued entry.
- issue_rd  out  PHYS_REGS_ADDR_WIDTH  destination tag.
- issue_ctrl  out  CTRL_WIDTH  control payload.

## Operation
- Entry fields: busy, op1, op1_valid, op2, op2_valid, rd, ctrl. An entry is ready when busy && op1_valid && op2_valid.
- **Allocation**
  - dispatch_ready = (free entries ≥ DISPATCH_WIDTH), computed from registered busy bits only.
  - Dispatch is accepted only when dispatch_ready=1.
  - Valid lanes, taken in ascending lane order, fill free entries in ascending index order. Invalid lanes consume no entry.
  - Lanes may be sparse (for example, lane 0 invalid and lane 1 valid).
- **Wakeup**
  - For every busy entry, and for every incoming dispatch lane in the same cycle: if opN_valid=0 and opN[PHYS_REGS_ADDR_WIDTH-1:0] equals any valid wakeup_tag, set opN_valid=1.
  - The operand value field is not rewritten. The executor reads the register file by tag.
  - Dispatch-cycle wakeup is mandatory, so a broadcast is never missed.
- **Select**
  - The lowest-index ready entry is presented.
  - issue_valid = any ready entry. issue_* are driven combinationally from that entry's registered fields.
  - On issue_valid && issue_ready, the entry's busy bit clears at the next edge.
  - While issue_ready=0, the presented entry may change only if a lower-index entry becomes ready.
- **Flush**
  - All busy bits clear at the next edge.
  - flush overrides a same-cycle dispatch and a same-cycle issue handshake: the accepted instruction is dropped.
  - Execute squashes the dropped instruction by flush itself.
- **Reset** (rst_n=0 at an edge): all busy=0. This gives issue_valid=0 and dispatch_ready=1. Entry payloads are don't-care.

## Timing
- Dispatch to earliest issue_valid: 1 cycle, provided both operands are valid at dispatch or woken in the dispatch cycle.
- Wakeup to issue_valid for an already-resident entry: 1 cycle.
- An entry freed by issue in cycle N is counted as free for dispatch_ready in cycle N+1, not N.
- Full queue: dispatch_ready=0. Dispatch and wakeup continue to operate on resident entries.
- A simultaneous dispatch, wakeup and issue in the same cycle are all honoured.
- Duplicate tags across wakeup ports are harmless.
- Reset mid-operation discards all entries. Outputs reach their reset values after that edge.

## Structure
- In the shared package: iq_entry_t (packed struct of the entry fields) and IQ_DEPTH.
- Sub-module iq_select: priority encoder returning the lowest ready index plus a found flag. It is reused later by the free-slot search.
- The free-slot search for allocation uses the same encoder on ~busy, masked iteratively for DISPATCH_WIDTH lanes.

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles -> issue_valid=0, dispatch_ready=1.
- **Immediate-ready:** dispatch lane 0 with op1_valid=op2_valid=1 (op2=32'h5, rd=7) and issue_ready=1 -> next cycle issue_valid=1, issue_op2=32'h5, issue_rd=7; the cycle after, issue_valid=0.
- **Wakeup:** dispatch with op1 tag 12 pending and op2 immediate; broadcast tag 12 three cycles later -> issue_valid rises the following cycle. A broadcast of tag 12 in the dispatch cycle itself -> issue_valid the next cycle.
- **Full / backpressure:** issue_ready=0; dispatch all-ready groups until full -> dispatch_ready=0 once free < DISPATCH_WIDTH. Issuing one entry at a time asserts dispatch_ready the cycle after the count crosses.
- **Select order:** entries 2 and 5 become ready in the same cycle, issue_ready=1 -> entry 2 issues first, entry 5 on the next cycle.
- **Flush:** flush together with dispatch_valid and issue handshake -> next cycle issue_valid=0, dispatch_ready=1, and no stale entry ever issues.
